// File: rtl/espi_strap_drv_pkg.sv
// Shared constants for the eSPI strap driver: FSM encoding and default timings.
package espi_strap_drv_pkg;

   localparam logic [7:0] SETUP_US_DEF = 8'd10;
   localparam logic [7:0] HOLD_US_DEF  = 8'd2;

   typedef logic [1:0] strapSt_t;

   localparam strapSt_t ST_DRIVE   = 2'd0;
   localparam strapSt_t ST_READY   = 2'd1;
   localparam strapSt_t ST_HOLD    = 2'd2;
   localparam strapSt_t ST_RELEASE = 2'd3;

   // Strap data follows the input only before the PCH has sampled it.
   function automatic logic strapTracks(input strapSt_t st);
      return (st == ST_DRIVE) || (st == ST_READY);
   endfunction

endpackage

// File: rtl/espi_strap_drv_if.sv
// Strap driver signal bundle: PCH reset, tick, strap pattern and pin controls.
interface espi_strap_drv_if #(
   parameter int STRAP_W = 4
);
   logic               i1uSCE;
   logic               iRsmRst_N;
   logic [STRAP_W-1:0] iStrapVal;
   logic               oStrapOe;
   logic [STRAP_W-1:0] oStrapData;
   logic               oMuxSel;
   logic               oSetupErr;

   modport master (
      output i1uSCE, iRsmRst_N, iStrapVal,
      input  oStrapOe, oStrapData, oMuxSel, oSetupErr
   );

   modport slave (
      input  i1uSCE, iRsmRst_N, iStrapVal,
      output oStrapOe, oStrapData, oMuxSel, oSetupErr
   );
endinterface

// File: rtl/espi_strap_drv_us_counter.sv
// Microsecond counter: synchronous clear, tick enable, saturates at 8'hFF.
module us_counter (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iClr,
   input  logic       iTick,
   input  logic [7:0] iCmpVal,
   output logic       oHit
);

   logic [7:0] rCount;

   // Clear wins over a coincident tick so a tick on a state change is dropped.
   always_ff @(posedge iClk) begin
      if (!iRst_n || iClr)
         rCount <= 8'd0;
      else if (iTick && (rCount != 8'hFF))
         rCount <= rCount + 8'd1;
   end

   assign oHit = (rCount == iCmpVal);

endmodule

// File: rtl/espi_strap_drv.sv
// eSPI strap driver: holds strap pins around RSMRST# deassertion, then hands
// the pins to the PCH through the mux with break-before-make ordering.
//
// state      | meaning
// ST_DRIVE   | straps driven, counting setup time
// ST_READY   | setup time met, waiting for RSMRST# deassertion
// ST_HOLD    | RSMRST# high, straps still driven for the hold time
// ST_RELEASE | straps released, mux hands pins to the PCH
module espi_strap_drv
   import espi_strap_drv_pkg::*;
#(
   parameter logic [7:0] SETUP_US = SETUP_US_DEF,
   parameter logic [7:0] HOLD_US  = HOLD_US_DEF,
   parameter int         STRAP_W  = 4
) (
   input  logic                    iClk,
   input  logic                    iRst_n,
   espi_strap_drv_if.slave         bus
);

   logic               rSync1;
   logic               rRsm;
   strapSt_t           rState;
   strapSt_t           nState;
   logic               setErr;
   logic               cntHit;
   logic               cntClr;
   logic               cntEn;
   logic [7:0]         cmpVal;
   logic               rStrapOe;
   logic               rMuxSel;
   logic               rSetupErr;
   logic [STRAP_W-1:0] rStrapData;

   // Two-flop synchronizer for the asynchronous RSMRST#.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         rSync1 <= 1'b0;
         rRsm   <= 1'b0;
      end else begin
         rSync1 <= bus.iRsmRst_N;
         rRsm   <= rSync1;
      end
   end

   // Next-state decode; an early RSMRST# rise flags a setup violation.
   always_comb begin
      nState = rState;
      setErr = 1'b0;
      case (rState)
         ST_DRIVE: begin
            if (cntHit)
               nState = rRsm ? ST_HOLD : ST_READY;
            else if (rRsm) begin
               nState = ST_HOLD;
               setErr = 1'b1;
            end
         end
         ST_READY:   if (rRsm) nState = ST_HOLD;
         ST_HOLD: begin
            if (!rRsm)
               nState = ST_DRIVE;
            else if (cntHit)
               nState = ST_RELEASE;
         end
         ST_RELEASE: if (!rRsm) nState = ST_DRIVE;
         default:    nState = ST_DRIVE;
      endcase
   end

   assign cntClr = (nState != rState);
   assign cntEn  = bus.i1uSCE && ((rState == ST_DRIVE) || (rState == ST_HOLD));
   assign cmpVal = (rState == ST_HOLD) ? HOLD_US : SETUP_US;

   us_counter u_us_counter (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iClr    (cntClr),
      .iTick   (cntEn),
      .iCmpVal (cmpVal),
      .oHit    (cntHit)
   );

   // State and registered outputs. OE drops on RELEASE entry and mux follows a
   // cycle later; on leaving RELEASE mux drops first and OE returns a cycle later.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         rState     <= ST_DRIVE;
         rStrapOe   <= 1'b1;
         rMuxSel    <= 1'b0;
         rSetupErr  <= 1'b0;
         rStrapData <= '0;
      end else begin
         rState    <= nState;
         rStrapOe  <= (nState != ST_RELEASE) && (rState != ST_RELEASE);
         rMuxSel   <= (nState == ST_RELEASE) && (rState == ST_RELEASE);
         rSetupErr <= rSetupErr | setErr;
         if (strapTracks(rState))
            rStrapData <= bus.iStrapVal;
      end
   end

   assign bus.oStrapOe   = rStrapOe;
   assign bus.oMuxSel    = rMuxSel;
   assign bus.oSetupErr  = rSetupErr;
   assign bus.oStrapData = rStrapData;

endmodule

// File: tb/tb_espi_strap_drv.sv
// Directed bench for espi_strap_drv; 1 us is modelled as 10 clocks.
module tb_espi_strap_drv;

   logic iClk;
   logic iRst_n;
   int   nVec;
   int   nErr;
   int   overlapCnt;

   espi_strap_drv_if #(.STRAP_W(4)) bus ();

   espi_strap_drv #(.SETUP_US(8'd10), .HOLD_US(8'd2), .STRAP_W(4)) dut (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .bus    (bus)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   always @(negedge iClk) begin
      if (iRst_n === 1'b1 && bus.oStrapOe === 1'b1 && bus.oMuxSel === 1'b1)
         overlapCnt++;
   end

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic us(input int n);
      for (int u = 0; u < n; u++) begin
         for (int k = 0; k < 10; k++) begin
            bus.i1uSCE = (k == 9);
            step();
         end
         bus.i1uSCE = 1'b0;
      end
   endtask

   task automatic do_reset();
      iRst_n = 1'b0;
      bus.iRsmRst_N = 1'b0;
      bus.i1uSCE = 1'b0;
      step();
      step();
      iRst_n = 1'b1;
   endtask

   task automatic test_reset();
      iRst_n = 1'b0;
      bus.iRsmRst_N = 1'b1;
      bus.iStrapVal = 4'hA;
      bus.i1uSCE = 1'b0;
      step();
      step();
      nVec++; if (bus.oStrapOe !== 1'b1) begin nErr++; $display("FAIL rst_oe got %b want 1", bus.oStrapOe); end
      nVec++; if (bus.oMuxSel !== 1'b0) begin nErr++; $display("FAIL rst_mux got %b want 0", bus.oMuxSel); end
      nVec++; if (bus.oSetupErr !== 1'b0) begin nErr++; $display("FAIL rst_err got %b want 0", bus.oSetupErr); end
      nVec++; if (bus.oStrapData !== 4'h0) begin nErr++; $display("FAIL rst_data got %h want 0", bus.oStrapData); end
   endtask

   task automatic test_normal();
      do_reset();
      bus.iStrapVal = 4'hA;
      us(20);
      nVec++; if (bus.oStrapData !== 4'hA) begin nErr++; $display("FAIL norm_data got %h want a", bus.oStrapData); end
      nVec++; if (bus.oStrapOe !== 1'b1 || bus.oMuxSel !== 1'b0) begin nErr++; $display("FAIL norm_drive oe=%b mux=%b want 1/0", bus.oStrapOe, bus.oMuxSel); end
      bus.iRsmRst_N = 1'b1;
      step(); step(); step();
      us(2);
      nVec++; if (bus.oStrapOe !== 1'b1) begin nErr++; $display("FAIL norm_hold_oe got %b want 1", bus.oStrapOe); end
      step();
      nVec++; if (bus.oStrapOe !== 1'b0 || bus.oMuxSel !== 1'b0) begin nErr++; $display("FAIL norm_oe_fall oe=%b mux=%b want 0/0", bus.oStrapOe, bus.oMuxSel); end
      step();
      nVec++; if (bus.oStrapOe !== 1'b0 || bus.oMuxSel !== 1'b1) begin nErr++; $display("FAIL norm_mux_rise oe=%b mux=%b want 0/1", bus.oStrapOe, bus.oMuxSel); end
      nVec++; if (bus.oSetupErr !== 1'b0) begin nErr++; $display("FAIL norm_err got %b want 0", bus.oSetupErr); end
   endtask

   task automatic test_setup_err();
      do_reset();
      us(5);
      bus.iRsmRst_N = 1'b1;
      step(); step();
      nVec++; if (bus.oSetupErr !== 1'b0) begin nErr++; $display("FAIL serr_early got %b want 0", bus.oSetupErr); end
      bus.i1uSCE = 1'b1;
      step();
      bus.i1uSCE = 1'b0;
      nVec++; if (bus.oSetupErr !== 1'b1) begin nErr++; $display("FAIL serr_set got %b want 1", bus.oSetupErr); end
      us(2);
      nVec++; if (bus.oStrapOe !== 1'b1) begin nErr++; $display("FAIL serr_tick_drop oe=%b want 1", bus.oStrapOe); end
      step();
      nVec++; if (bus.oStrapOe !== 1'b0 || bus.oMuxSel !== 1'b0) begin nErr++; $display("FAIL serr_oe_fall oe=%b mux=%b want 0/0", bus.oStrapOe, bus.oMuxSel); end
      step();
      nVec++; if (bus.oMuxSel !== 1'b1 || bus.oSetupErr !== 1'b1) begin nErr++; $display("FAIL serr_release mux=%b err=%b want 1/1", bus.oMuxSel, bus.oSetupErr); end
   endtask

   task automatic test_hold_abort();
      do_reset();
      bus.iStrapVal = 4'hA;
      us(12);
      bus.iRsmRst_N = 1'b1;
      step(); step(); step();
      bus.iStrapVal = 4'h5;
      us(1);
      nVec++; if (bus.oStrapData !== 4'hA) begin nErr++; $display("FAIL abort_freeze got %h want a", bus.oStrapData); end
      bus.iRsmRst_N = 1'b0;
      step(); step(); step();
      nVec++; if (bus.oMuxSel !== 1'b0 || bus.oStrapOe !== 1'b1) begin nErr++; $display("FAIL abort_pins oe=%b mux=%b want 1/0", bus.oStrapOe, bus.oMuxSel); end
      nVec++; if (bus.oStrapData !== 4'hA) begin nErr++; $display("FAIL abort_data_lag got %h want a", bus.oStrapData); end
      step();
      nVec++; if (bus.oStrapData !== 4'h5) begin nErr++; $display("FAIL abort_data_track got %h want 5", bus.oStrapData); end
      us(9);
      bus.iRsmRst_N = 1'b1;
      step(); step(); step();
      nVec++; if (bus.oSetupErr !== 1'b1) begin nErr++; $display("FAIL abort_cnt_restart err=%b want 1", bus.oSetupErr); end
   endtask

   task automatic test_back_to_back();
      int startOv;
      startOv = overlapCnt;
      do_reset();
      us(11);
      bus.iRsmRst_N = 1'b1;
      step(); step(); step();
      us(2);
      step(); step();
      nVec++; if (bus.oMuxSel !== 1'b1) begin nErr++; $display("FAIL b2b_rel1 mux=%b want 1", bus.oMuxSel); end
      bus.iRsmRst_N = 1'b0;
      step(); step();
      nVec++; if (bus.oMuxSel !== 1'b1 || bus.oStrapOe !== 1'b0) begin nErr++; $display("FAIL b2b_sync oe=%b mux=%b want 0/1", bus.oStrapOe, bus.oMuxSel); end
      step();
      nVec++; if (bus.oMuxSel !== 1'b0 || bus.oStrapOe !== 1'b0) begin nErr++; $display("FAIL b2b_mux_first oe=%b mux=%b want 0/0", bus.oStrapOe, bus.oMuxSel); end
      step();
      nVec++; if (bus.oMuxSel !== 1'b0 || bus.oStrapOe !== 1'b1) begin nErr++; $display("FAIL b2b_oe_back oe=%b mux=%b want 1/0", bus.oStrapOe, bus.oMuxSel); end
      us(12);
      bus.iRsmRst_N = 1'b1;
      step(); step(); step();
      us(2);
      nVec++; if (bus.oStrapOe !== 1'b1) begin nErr++; $display("FAIL b2b_hold2 oe=%b want 1", bus.oStrapOe); end
      step();
      nVec++; if (bus.oStrapOe !== 1'b0 || bus.oMuxSel !== 1'b0) begin nErr++; $display("FAIL b2b_oe_fall2 oe=%b mux=%b want 0/0", bus.oStrapOe, bus.oMuxSel); end
      step();
      nVec++; if (bus.oStrapOe !== 1'b0 || bus.oMuxSel !== 1'b1) begin nErr++; $display("FAIL b2b_mux_rise2 oe=%b mux=%b want 0/1", bus.oStrapOe, bus.oMuxSel); end
      nVec++; if (overlapCnt !== startOv) begin nErr++; $display("FAIL b2b_overlap cycles=%0d want 0", overlapCnt - startOv); end
      nVec++; if (bus.oSetupErr !== 1'b0) begin nErr++; $display("FAIL b2b_err got %b want 0", bus.oSetupErr); end
   endtask

   task automatic test_reset_in_release();
      do_reset();
      us(3);
      bus.iRsmRst_N = 1'b1;
      step(); step(); step();
      us(2);
      step(); step();
      nVec++; if (bus.oMuxSel !== 1'b1 || bus.oSetupErr !== 1'b1) begin nErr++; $display("FAIL rrel_pre mux=%b err=%b want 1/1", bus.oMuxSel, bus.oSetupErr); end
      iRst_n = 1'b0;
      step();
      nVec++; if (bus.oStrapOe !== 1'b1 || bus.oMuxSel !== 1'b0) begin nErr++; $display("FAIL rrel_pins oe=%b mux=%b want 1/0", bus.oStrapOe, bus.oMuxSel); end
      nVec++; if (bus.oSetupErr !== 1'b0) begin nErr++; $display("FAIL rrel_err got %b want 0", bus.oSetupErr); end
      nVec++; if (bus.oStrapData !== 4'h0) begin nErr++; $display("FAIL rrel_data got %h want 0", bus.oStrapData); end
      iRst_n = 1'b1;
   endtask

   initial begin
      nVec = 0;
      nErr = 0;
      overlapCnt = 0;
      iRst_n = 1'b0;
      bus.i1uSCE = 1'b0;
      bus.iRsmRst_N = 1'b0;
      bus.iStrapVal = 4'h0;
      test_reset();
      test_normal();
      test_setup_err();
      test_hold_abort();
      test_back_to_back();
      test_reset_in_release();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
